// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: segment codes and scan states.
package hex_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low gfedcba patterns; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with hold and leading-zero blanking.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    input  logic                  Hold_n,
    input  logic                  Blank_lz,
    output logic [6:0]            Seg_n,
    output logic [DIGITS-1:0]     Digit_en_n,
    output logic [4*DIGITS-1:0]   Shown
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                hold_meta;
    logic                hold_s;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    scan_state_e         state_q;
    scan_state_e         state_d;
    logic [6:0]          seg_d;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   en_d;
    logic [4*DIGITS-1:0] upper;
    logic                lz_blank;

    // Two-flop synchroniser for the asynchronous pushbutton.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hold_meta <= 1'b1;
            hold_s    <= 1'b1;
        end else begin
            hold_meta <= Hold_n;
            hold_s    <= hold_meta;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Shown <= '0;
        end else if (Load && hold_s) begin
            Shown <= Value;
        end
    end

    // Nibbles from the selected digit upward; all-zero means a leading zero.
    assign upper    = Shown >> (4 * int'(idx_q));
    assign lz_blank = Blank_lz && (idx_q != '0) && (upper == '0);

    hex_to_7seg u_dec (
        .nibble (upper[3:0]),
        .seg_n  (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seg_d   = SEG_OFF;
        en_d    = '1;
        unique case (state_q)
            BLANK: begin
                state_d = DRIVE;
            end
            DRIVE: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    en_d[i] = (idx_q != IDX_W'(i));
                end
                seg_d = lz_blank ? SEG_OFF : dec_seg;
                if (div_q == DIV_LAST) begin
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = BLANK;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_q      <= '0;
            idx_q      <= '0;
            state_q    <= BLANK;
            Seg_n      <= SEG_OFF;
            Digit_en_n <= '1;
        end else begin
            div_q      <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            idx_q      <= idx_d;
            state_q    <= state_d;
            Seg_n      <= seg_d;
            Digit_en_n <= en_d;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: cycle-count display model plus directed literal checks.
module tb_hex_display_scanner;

    localparam int ND = 5;
    localparam int RD = 4;
    localparam logic [6:0] SEG_LIT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [4:0] EN_LIT [5]  = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
    localparam logic [6:0] SEG_A [5]   = '{7'h30, 7'h0E, 7'h24, 7'h08, 7'h79};
    localparam logic [6:0] SEG_LZ1 [5] = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [6:0] SEG_LZ0 [5] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Load;
    logic        Hold_n;
    logic        Blank_lz;
    logic [19:0] Value;
    logic [6:0]  Seg_n;
    logic [4:0]  Digit_en_n;
    logic [19:0] Shown;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;

    hex_display_scanner #(
        .DIGITS      (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Value      (Value),
        .Load       (Load),
        .Hold_n     (Hold_n),
        .Blank_lz   (Blank_lz),
        .Seg_n      (Seg_n),
        .Digit_en_n (Digit_en_n),
        .Shown      (Shown)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge n after reset is an off gap when (n-1)%RD==0, else it shows slot ((n-1)/RD)%ND.
    int          m_n     = 0;
    logic [19:0] m_shown = '0;
    logic [6:0]  m_seg   = 7'h7F;
    logic [4:0]  m_en    = 5'h1F;
    logic        m_h1    = 1'b1;
    logic        m_h2    = 1'b1;

    function automatic logic [4:0] en_at(int n);
        if ((n - 1) % RD == 0) return 5'h1F;
        return 5'h1F ^ 5'(1 << (((n - 1) / RD) % ND));
    endfunction

    function automatic logic [6:0] seg_at(int n, logic [19:0] shown, logic blz);
        int          sl;
        logic [19:0] up;
        if ((n - 1) % RD == 0) return 7'h7F;
        sl = ((n - 1) / RD) % ND;
        up = shown >> (4 * sl);
        if (blz && sl > 0 && up == 20'h0) return 7'h7F;
        return SEG_LIT[up[3:0]];
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_n     <= 0;
            m_shown <= '0;
            m_seg   <= 7'h7F;
            m_en    <= 5'h1F;
            m_h1    <= 1'b1;
            m_h2    <= 1'b1;
        end else begin
            m_n   <= m_n + 1;
            m_en  <= en_at(m_n + 1);
            m_seg <= seg_at(m_n + 1, m_shown, Blank_lz);
            if (Load && m_h2) m_shown <= Value;
            m_h1 <= Hold_n;
            m_h2 <= m_h1;
        end
    end

    always @(negedge Clock) begin
        check("seg_n", 32'(Seg_n), 32'(m_seg));
        check("digit_en_n", 32'(Digit_en_n), 32'(m_en));
        check("shown", 32'(Shown), 32'(m_shown));
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        edge_no++;
    endtask

    task automatic run_to(input int target);
        while (edge_no < target) tick();
    endtask

    task automatic check_slot(input string name, input logic [4:0] en, input logic [6:0] seg);
        check({name, "_en"}, 32'(Digit_en_n), 32'(en));
        check({name, "_seg"}, 32'(Seg_n), 32'(seg));
    endtask

    initial begin
        Reset    = 1'b1;
        Load     = 1'b0;
        Hold_n   = 1'b1;
        Blank_lz = 1'b0;
        Value    = '0;
        #1;
        check_slot("reset", 5'h1F, 7'h7F);
        check("reset_shown", 32'(Shown), 32'h0);
        tick();
        tick();
        Reset   = 1'b0;
        edge_no = 0;

        // Load 0x1A2F3 and walk one full frame plus the wrap.
        Value = 20'h1A2F3;
        Load  = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 1) begin
                Load = 1'b0;
                check("load_shown", 32'(Shown), 32'h1A2F3);
            end
            if ((e - 1) % 4 == 0) check_slot("scan_gap", 5'h1F, 7'h7F);
            else check_slot("scan", EN_LIT[((e - 1) / 4) % 5], SEG_A[((e - 1) / 4) % 5]);
        end

        // Hold: Hold_n low before edges 1..10, Value increments every edge.
        Value  = 20'h00200;
        Load   = 1'b1;
        Hold_n = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 11) Hold_n = 1'b1;
            tick();
            if (k == 1) check("hold_pre", 32'(Shown), 32'h00200);
            else if (k <= 12) check("hold_frozen", 32'(Shown), 32'h00201);
            else check("hold_release", 32'(Shown), 32'h0020C);
            Value = Value + 20'h1;
        end
        Load = 1'b0;

        // Reset mid-run, then leading-zero blanking from a fresh frame.
        tick();
        Reset = 1'b1;
        #1;
        check_slot("midreset", 5'h1F, 7'h7F);
        check("midreset_shown", 32'(Shown), 32'h0);
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        edge_no  = 0;
        Value    = 20'h000A0;
        Load     = 1'b1;
        Blank_lz = 1'b1;
        tick();
        Load = 1'b0;
        check("lz_shown", 32'(Shown), 32'h000A0);
        for (int s = 0; s < 5; s++) begin
            run_to(2 + 4 * s);
            check_slot("lz_a0", EN_LIT[s], SEG_LZ1[s]);
        end
        Value = 20'h0;
        Load  = 1'b1;
        tick();
        Load = 1'b0;
        for (int s = 0; s < 5; s++) begin
            run_to(22 + 4 * s);
            check_slot("lz_zero", EN_LIT[s], SEG_LZ0[s]);
        end

        // New capture inside a digit-0 slot shows on the next edge.
        run_to(41);
        Value = 20'h00005;
        Load  = 1'b1;
        tick();
        Load = 1'b0;
        check_slot("midslot_old", 5'h1E, 7'h40);
        tick();
        check_slot("midslot_new", 5'h1E, 7'h12);

        // Sweep digit 0 through all 16 codes.
        for (int v = 0; v < 16; v++) begin
            run_to(61 + 20 * v);
            Value = 20'h1A2F0 | 20'(v);
            Load  = 1'b1;
            tick();
            Load = 1'b0;
            tick();
            check_slot("sweep", 5'h1E, SEG_LIT[v]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
